// File: rtl/pow2_pkg.sv
// Shared definitions for the power-of-two sequential classifier.
//   pow2_state_t : scan FSM states
//   DEF_WIDTH    : default operand width, shared with consumers and benches
package pow2_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } pow2_state_t;

endpackage : pow2_pkg

// File: rtl/pow2_seq_checker.sv
// Handshaked bit-serial power-of-two classifier.
// Accepts an operand on in_valid/in_ready, scans it LSB-first for WIDTH cycles,
// then presents is_pow2 / highest-set-bit index / popcount on out_valid/out_ready.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid, in_ready, in_num : operand handshake and data
//   out_valid, out_ready       : result handshake
//   out_is_pow2, out_log2, out_ones : result fields (held while out_valid)
module pow2_seq_checker
    import pow2_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IW    = $clog2(WIDTH),
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_pow2,
    output logic [IW-1:0]    out_log2,
    output logic [CW-1:0]    out_ones
);

    pow2_state_t      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    pos_q, pos_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             is_pow2_q, is_pow2_d;
    logic [IW-1:0]    log2_q, log2_d;
    logic [CW-1:0]    res_ones_q, res_ones_d;

    // Per-bit update of the running popcount and highest-set-bit index
    logic [CW-1:0]    ones_nxt;
    logic [IW-1:0]    pos_nxt;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            pos_q       <= '0;
            ones_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            is_pow2_q   <= 1'b0;
            log2_q      <= '0;
            res_ones_q  <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            ones_q      <= ones_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            is_pow2_q   <= is_pow2_d;
            log2_q      <= log2_d;
            res_ones_q  <= res_ones_d;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        ones_d      = ones_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        is_pow2_d   = is_pow2_q;
        log2_d      = log2_q;
        res_ones_d  = res_ones_q;

        ones_nxt    = ones_q + CW'(sr_q[0]);
        pos_nxt     = sr_q[0] ? cnt_q : pos_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sr_d       = in_num;
                    cnt_d      = '0;
                    ones_d     = '0;
                    pos_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                ones_d = ones_nxt;
                pos_d  = pos_nxt;
                sr_d   = sr_q >> 1;
                cnt_d  = cnt_q + IW'(1);
                // Last bit processed: publish the final totals
                if (cnt_q == IW'(WIDTH - 1)) begin
                    is_pow2_d   = (ones_nxt == CW'(1));
                    log2_d      = pos_nxt;
                    res_ones_d  = ones_nxt;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_is_pow2 = is_pow2_q;
    assign out_log2    = log2_q;
    assign out_ones    = res_ones_q;

endmodule : pow2_seq_checker

// File: tb/tb_pow2_seq_checker.sv
// Self-checking bench for pow2_seq_checker (WIDTH = 8): directed table,
// multi-cycle corner sequences, and a randomized stream against a reference model.
module tb_pow2_seq_checker;
    import pow2_pkg::*;

    localparam int unsigned W  = DEF_WIDTH;
    localparam int unsigned IW = $clog2(W);
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_num = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_is_pow2;
    logic [IW-1:0] out_log2;
    logic [CW-1:0] out_ones;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    pow2_seq_checker #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_num     (in_num),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_is_pow2(out_is_pow2),
        .out_log2   (out_log2),
        .out_ones   (out_ones)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] num;
        int           p;
        int           lg;
        int           ones;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: arithmetic definitions, not a bit-serial scan
    function automatic void model(input logic [W-1:0] n, output int p,
                                  output int lg, output int ones);
        int v;
        v    = int'(n);
        ones = 0;
        lg   = 0;
        for (int i = 0; i < int'(W); i++) if ((v >> i) % 2 == 1) ones++;
        while ((1 << (lg + 1)) <= v) lg++;
        p = (v != 0 && (v & (v - 1)) == 0) ? 1 : 0;
    endfunction

    task automatic chk_res(input string name, input int p, input int lg, input int ones);
        chk({name, ".is_pow2"}, int'(out_is_pow2), p);
        chk({name, ".log2"},    int'(out_log2),    lg);
        chk({name, ".ones"},    int'(out_ones),    ones);
    endtask

    // One full transaction: accept, latency, optional backpressure, retire
    task automatic run_op(input string name, input logic [W-1:0] num,
                          input int p, input int lg, input int ones,
                          input int hold, input bit chg, input logic [W-1:0] chg_num);
        int t;
        int lat;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        chk({name, ".ready_wait_timeout"}, int'(t < 50), 1);
        in_valid = 1'b1;
        in_num   = num;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (chg) in_num = chg_num;
        chk({name, ".in_ready_drop"}, int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({name, ".latency"}, lat, int'(W));
        chk_res(name, p, lg, ones);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, ".hold_valid"}, int'(out_valid), 1);
            chk({name, ".hold_in_ready"}, int'(in_ready), 0);
            chk_res({name, ".hold"}, p, lg, ones);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".retire_valid"}, int'(out_valid), 0);
        chk({name, ".retire_ready"}, int'(in_ready), 1);
    endtask

    vec_t tbl[6];

    initial begin
        int ep, el, eo;

        tbl[0] = '{8'd0,   0, 0, 0};
        tbl[1] = '{8'd1,   1, 0, 1};
        tbl[2] = '{8'd2,   1, 1, 1};
        tbl[3] = '{8'd128, 1, 7, 1};
        tbl[4] = '{8'd6,   0, 2, 2};
        tbl[5] = '{8'd255, 0, 7, 8};

        // Reset state
        #12;
        chk("rst.in_ready", int'(in_ready), 1);
        chk("rst.out_valid", int'(out_valid), 0);
        chk_res("rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (tbl[i])
            run_op($sformatf("tbl%0d", i), tbl[i].num, tbl[i].p, tbl[i].lg, tbl[i].ones,
                   0, 1'b0, '0);

        // Backpressure on 64
        run_op("bp64", 8'd64, 1, 6, 1, 5, 1'b0, '0);

        // Input change while busy: 3 captured, 8 ignored
        run_op("busy_chg", 8'd3, 0, 1, 2, 0, 1'b1, 8'd8);

        // Back-to-back stream with out_ready held high
        begin
            logic [W-1:0] ops[3];
            int acc_cyc[3];
            int ri, ai, guard;
            ops = '{8'd4, 8'd5, 8'd16};
            ri = 0; ai = 0; guard = 0;
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_num    = ops[0];
            while (ri < 3 && guard < 100) begin
                if (out_valid) begin
                    model(ops[ri], ep, el, eo);
                    chk_res($sformatf("b2b%0d", ri), ep, el, eo);
                    ri++;
                end
                if (in_valid && in_ready) begin
                    acc_cyc[ai] = cyc;
                    ai++;
                    @(negedge clk);
                    if (ai < 3) in_num = ops[ai];
                    else in_valid = 1'b0;
                end else begin
                    @(negedge clk);
                end
                guard++;
            end
            chk("b2b.timeout", int'(guard < 100), 1);
            chk("b2b.accepts", ai, 3);
            if (ai == 3) begin
                chk("b2b.gap01", acc_cyc[1] - acc_cyc[0], int'(W) + 2);
                chk("b2b.gap12", acc_cyc[2] - acc_cyc[1], int'(W) + 2);
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end

        // Reset during 4th SCAN cycle of 32
        begin
            int seen;
            @(negedge clk);
            in_valid = 1'b1;
            in_num   = 8'd32;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("mid_rst.in_ready", int'(in_ready), 1);
            chk("mid_rst.out_valid", int'(out_valid), 0);
            chk_res("mid_rst", 0, 0, 0);
            @(negedge clk);
            rst_n = 1'b1;
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("mid_rst.no_valid", seen, 0);
            run_op("after_rst8", 8'd8, 1, 3, 1, 0, 1'b0, '0);
        end

        // Randomized stream against the reference model
        begin
            logic [W-1:0] expq[$];
            logic [W-1:0] pend;
            int done_n, guard, ext;
            done_n = 0; guard = 0;
            @(negedge clk);
            while (done_n < 60 && guard < 5000) begin
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        chk("rnd.spurious", 1, 0);
                    end else begin
                        pend = expq.pop_front();
                        model(pend, ep, el, eo);
                        chk_res($sformatf("rnd%0d", done_n), ep, el, eo);
                    end
                    done_n++;
                end
                if (in_valid && in_ready) expq.push_back(in_num);
                if (out_valid && in_ready) chk("rnd.excl", 1, 0);
                ext = (in_valid && in_ready) ? 1 : 0;
                @(negedge clk);
                if (!in_valid || ext == 1) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_num   = W'($urandom);
                end
                out_ready = ($urandom_range(0, 2) != 0);
                guard++;
            end
            chk("rnd.timeout", int'(guard < 5000), 1);
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pow2_seq_checker

// File: doc/pow2_seq_checker.md
# pow2_seq_checker

Sequential, handshaked power-of-two classifier. It sits directly upstream of the combinational `is_power_of_two` consumer logic and replaces it wherever numbers arrive as a stream. Each accepted operand is scanned one bit per cycle by a small FSM. It reports whether the operand is a power of two, the index of its highest set bit, and its popcount.

## Interface
- `WIDTH`, default 8: operand width in bits, minimum 2.
- `IW`, default `$clog2(WIDTH)`: width of the bit-index field (derived; do not override).
- `CW`, default `$clog2(WIDTH+1)`: width of the popcount field (derived; do not override).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand present.
- `in_ready` output 1: block can accept an operand.
- `in_num` input WIDTH: operand, unsigned.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `out_is_pow2` output 1: 1 iff exactly one bit of the operand is set.
- `out_log2` output IW: index of the highest set bit; 0 when the operand is 0.
- `out_ones` output CW: popcount of the operand.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`:
    - shift register ← `in_num`;
    - bit counter ← 0, ones ← 0, pos ← 0;
    - go to SCAN.
- **SCAN**
  - `in_ready` = 0.
  - Each cycle:
    - if `sr[0]`: ones ← ones+1 and pos ← bit counter;
    - sr ← sr >> 1;
    - bit counter ← bit counter + 1.
  - After the cycle that processes bit WIDTH-1, go to DONE and register the outputs:
    - `out_is_pow2` ← (ones_final == 1);
    - `out_log2` ← pos_final;
    - `out_ones` ← ones_final.
- **DONE**
  - `out_valid` = 1.
  - Outputs held stable until `out_valid && out_ready`, then go to IDLE.
- Scan length is always WIDTH cycles. There is no early exit, so latency is data-independent.
- Operand 0 gives is_pow2 = 0, log2 = 0, ones = 0.
- Popcount arithmetic is unsigned and cannot overflow: CW bits hold the value WIDTH.
- `in_num` is sampled only on the accept edge; changes at any other time are ignored.
- `out_*` data fields keep their last value until the next DONE entry; they are meaningful only while `out_valid` = 1.

## Timing
- Reset (asynchronous, any state, including mid-SCAN):
  - state = IDLE;
  - `in_ready` = 1, `out_valid` = 0;
  - `out_is_pow2` = 0, `out_log2` = 0, `out_ones` = 0;
  - all internal counters and the shift register = 0.
  - An in-flight operand is discarded.
- Accept at rising edge k:
  - `in_ready` falls after edge k;
  - SCAN spans edges k+1 … k+WIDTH;
  - `out_valid` rises after edge k+WIDTH (latency WIDTH cycles).
- Result taken at edge m:
  - `out_valid` falls and `in_ready` rises after edge m.
  - The next accept is at edge m+1 at the earliest. No accept in the same cycle as result retirement.
- Minimum issue interval is WIDTH+2 cycles.
- `out_ready` held high in advance: the result is taken at the first edge with `out_valid` = 1.
- `in_valid` asserted during SCAN or DONE: not accepted. The source must hold it and its data (standard valid/ready rule).
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Package `pow2_pkg` holds:
  - the state enum `pow2_state_t` (IDLE, SCAN, DONE);
  - the `DEF_WIDTH` constant (8), shared with the downstream consumer and the benches.
- Single module. No sub-module is warranted: the datapath is one shifter plus two counters.
- Estimated size: about 150 lines of RTL.

## Test plan
All scenarios use WIDTH=8.
- **Zeros and ones:** `in_num` = 0 → is_pow2=0, log2=0, ones=0. `in_num` = 1 → is_pow2=1, log2=0, ones=1. `out_valid` is high exactly 8 cycles after each accept.
- **Powers of two and non-powers:** `in_num` = 2 → 1/1/1. `in_num` = 128 → 1/7/1. `in_num` = 6 → 0/2/2. `in_num` = 255 → 0/7/8.
- **Backpressure:** `out_ready` = 0 for 5 cycles after `out_valid` on operand 64. Outputs hold 1/6/1 throughout and `in_ready` stays 0. Raising `out_ready` retires the result, and `in_ready` = 1 on the next cycle.
- **Back-to-back stream:** `in_valid` held high with operands 4, 5, 16 and `out_ready` = 1. Results are 1/2/1, 0/2/2, 1/4/1, in order, with 10 cycles between accepts.
- **Reset mid-scan:** assert `rst_n` = 0 during the 4th SCAN cycle of operand 32. Outputs clear immediately, `in_ready` = 1, and no `out_valid` appears for the discarded operand. Operand 8 afterwards → 1/3/1.
- **Input ignored while busy:** change `in_num` during SCAN from 3 to 8. The result is 0/1/2, i.e. the operand captured at accept is used.
